// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream, writes 16-bit words into
// program RAM and holds the CPU in reset until a frame loads with a good
// checksum. An inter-byte timer aborts frames that stall.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for HDR, nothing loaded yet since reset
// S_ADDR_LO | expecting start address low byte
// S_ADDR_HI | expecting start address high byte (bit 7 dropped)
// S_CNT_LO  | expecting word count low byte
// S_CNT_HI  | expecting word count high byte
// S_DATA_LO | expecting low byte of next word
// S_DATA_HI | expecting high byte of next word, write issued after it
// S_CHECK   | expecting checksum byte
// S_DONE    | last frame good, CPU released, waiting for HDR
// S_ERR     | last frame bad or timed out, CPU held, waiting for HDR
module prog_loader #(
  parameter int         TIMEOUT = 1_000_000,
  parameter logic [7:0] HDR     = 8'hA5
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [14:0] pram_addr,
  output logic [15:0] pram_data,
  output logic        pram_wren,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int             TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI,
    S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_active;
  logic           w_hdr;
  logic [TW-1:0]  r_timer;
  logic [14:0]    r_addr;
  logic [15:0]    r_cnt;
  logic [7:0]     r_lo;
  logic [7:0]     r_sum;
  logic [14:0]    r_paddr;
  logic [15:0]    r_pdata;
  logic           r_wren;

  assign pram_addr = r_paddr;
  assign pram_data = r_pdata;
  assign pram_wren = r_wren;

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and status outputs; a timer expiry overrides everything.
  always_comb begin
    w_next   = r_state;
    w_hdr    = rx_valid && (rx_data == HDR);
    w_active = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_hdr) w_next = S_ADDR_LO;
      S_ADDR_LO: begin
        w_active = 1'b1;
        if (rx_valid) w_next = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        w_active = 1'b1;
        if (rx_valid) w_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        w_active = 1'b1;
        if (rx_valid) w_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        w_active = 1'b1;
        if (rx_valid) w_next = ({rx_data, r_cnt[7:0]} == 16'd0) ? S_CHECK : S_DATA_LO;
      end
      S_DATA_LO: begin
        w_active = 1'b1;
        if (rx_valid) w_next = S_DATA_HI;
      end
      S_DATA_HI: begin
        w_active = 1'b1;
        if (rx_valid) w_next = (r_cnt == 16'd1) ? S_CHECK : S_DATA_LO;
      end
      S_CHECK: begin
        w_active = 1'b1;
        if (rx_valid) w_next = (rx_data == r_sum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_active && !rx_valid && (r_timer == TLAST)) w_next = S_ERR;
    done     = (r_state == S_DONE);
    error    = (r_state == S_ERR);
    cpu_hold = (r_state != S_DONE);
  end

  // Frame datapath: header fields, checksum, inter-byte timer and RAM write port.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_sum   <= '0;
      r_paddr <= '0;
      r_pdata <= '0;
      r_wren  <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      if (w_active && !rx_valid) r_timer <= r_timer + TW'(1);
      else                       r_timer <= '0;
      if (rx_valid) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: if (w_hdr) r_sum <= 8'd0;
          S_ADDR_LO: r_addr[7:0]  <= rx_data;
          S_ADDR_HI: r_addr[14:8] <= rx_data[6:0];
          S_CNT_LO:  r_cnt[7:0]   <= rx_data;
          S_CNT_HI:  r_cnt[15:8]  <= rx_data;
          S_DATA_LO: r_lo         <= rx_data;
          S_DATA_HI: begin
            r_wren  <= 1'b1;
            r_pdata <= {rx_data, r_lo};
            r_paddr <= r_addr;
            r_addr  <= r_addr + 15'd1;
            r_cnt   <= r_cnt - 16'd1;
          end
          default: ;
        endcase
        // Everything between HDR and CHK feeds the checksum.
        if (r_state inside {S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI})
          r_sum <= r_sum + rx_data;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames, timeout, mid-frame
// reset and randomized frames compared against a frame-level model.
module tb_prog_loader;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [14:0] pram_addr;
  logic [15:0] pram_data;
  logic        pram_wren;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frame_q[$];
  logic [30:0] exp_q[$];
  logic [30:0] got_q[$];
  logic        exp_done;

  prog_loader #(.TIMEOUT(16), .HDR(8'hA5)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .pram_addr(pram_addr),
    .pram_data(pram_data),
    .pram_wren(pram_wren),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #10 clk_in = ~clk_in;

  // Capture every RAM write away from the active edge.
  always @(negedge clk_in) if (pram_wren) got_q.push_back({pram_addr, pram_data});

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(255, 0);
    repeat (gap) begin @(posedge clk_in); #1; end
  endtask

  task automatic send_frame(input int lo_gap, input int hi_gap);
    foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(hi_gap, lo_gap));
  endtask

  // Expected writes and outcome straight from the frame layout.
  task automatic model_frame();
    int a_lo, a_hi, c_lo, c_hi, base, cnt, sum, last;
    logic [14:0] wa;
    exp_q.delete();
    last = frame_q.size() - 1;
    a_lo = frame_q[1]; a_hi = frame_q[2]; c_lo = frame_q[3]; c_hi = frame_q[4];
    base = a_lo + (a_hi % 128) * 256;
    cnt  = c_lo + c_hi * 256;
    sum  = 0;
    for (int i = 1; i < last; i++) sum += int'(frame_q[i]);
    for (int w = 0; w < cnt; w++) begin
      wa = 15'((base + w) % 32768);
      exp_q.push_back({wa, frame_q[6 + 2*w], frame_q[5 + 2*w]});
    end
    exp_done = ((sum % 256) == int'(frame_q[last]));
  endtask

  task automatic run_frame(input string name, input int lo_gap, input int hi_gap);
    model_frame();
    got_q.delete();
    send_frame(lo_gap, hi_gap);
    repeat (2) begin @(posedge clk_in); #1; end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s write[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                   name, i, got_q[i][30:16], got_q[i][15:0], exp_q[i][30:16], exp_q[i][15:0]);
        end
      end
    end
    checks++;
    if (done !== exp_done || error !== !exp_done || cpu_hold !== !exp_done) begin
      failures++;
      $display("FAIL %s status: got done=%b error=%b hold=%b expected done=%b error=%b hold=%b",
               name, done, error, cpu_hold, exp_done, !exp_done, !exp_done);
    end
  endtask

  task automatic build_random(input int maxcnt, input bit bad);
    int cnt, sum;
    logic [7:0] chk;
    frame_q.delete();
    cnt = $urandom_range(maxcnt, 0);
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'($urandom_range(255, 0)));
    frame_q.push_back(8'($urandom_range(255, 0)));
    frame_q.push_back(8'(cnt));
    frame_q.push_back(8'(cnt / 256));
    for (int i = 0; i < 2*cnt; i++) frame_q.push_back(8'($urandom_range(255, 0)));
    sum = 0;
    for (int i = 1; i < frame_q.size(); i++) sum += int'(frame_q[i]);
    chk = 8'(sum);
    if (bad) chk = chk + 8'($urandom_range(255, 1));
    frame_q.push_back(chk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk_in); #1;
    checks++; if (pram_addr !== 15'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0000", pram_addr); end
    checks++; if (pram_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", pram_data); end
    checks++; if (pram_wren !== 1'b0)  begin failures++; $display("FAIL reset_wren: got %b expected 0", pram_wren); end
    checks++; if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
    checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0)      begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
    reset = 1'b0;
    got_q.delete();
    // Non-header bytes in idle must be ignored, including a would-be frame body.
    send_byte(8'h10, 0); send_byte(8'h00, 1); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h00, 2);
    checks++;
    if (got_q.size() !== 0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: got writes=%0d hold=%b done=%b error=%b expected 0 1 0 0",
               got_q.size(), cpu_hold, done, error);
    end
  endtask

  task automatic test_directed();
    // Checksum covers data bytes too: correct CHK for this frame is D0.
    frame_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hD0};
    run_frame("two_words_good", 0, 2);
    frame_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h13};
    run_frame("two_words_bad13", 0, 2);
    frame_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h12};
    run_frame("two_words_bad12", 0, 2);
    frame_q = '{8'hA5, 8'hFF, 8'h7F, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h83};
    run_frame("addr_wrap", 0, 2);
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("zero_count", 0, 2);
    frame_q = '{8'hA5, 8'hA5, 8'hFF, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hF0};
    run_frame("hdr_as_data", 0, 1);
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    repeat (15) @(posedge clk_in); #1;
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL timeout_early: got error=%b expected 0", error); end
    @(posedge clk_in); #1;
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL timeout_hit: got error=%b hold=%b done=%b expected 1 1 0", error, cpu_hold, done);
    end
    frame_q = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hD0};
    run_frame("after_timeout", 0, 1);
    build_random(3, 1'b0);
    run_frame("max_gap15", 15, 15);
  endtask

  task automatic test_mid_reset();
    got_q.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk_in); #1;
    checks++;
    if (pram_wren !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got wren=%b hold=%b done=%b error=%b expected 0 1 0 0",
               pram_wren, cpu_hold, done, error);
    end
    reset = 1'b0;
    // If the block had kept its place, this byte would complete a write.
    send_byte(8'h12, 3);
    checks++;
    if (got_q.size() !== 0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_idle: got writes=%0d hold=%b expected 0 1", got_q.size(), cpu_hold);
    end
  endtask

  task automatic test_back_to_back();
    build_random(8, 1'b0);
    run_frame("b2b_good", 0, 0);
    build_random(8, 1'b1);
    run_frame("b2b_bad", 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [7:0] junk;
      for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
        junk = 8'($urandom_range(255, 0));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, $urandom_range(3, 0));
      end
      build_random(6, ($urandom_range(9, 0) < 3));
      run_frame($sformatf("rand%0d", n), 0, 4);
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    test_reset();
    test_directed();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
